// File: rtl/key_speed_sel.sv
// key_speed_sel: debounced 4-key selector driving a one-hot blink speed step.
// Define KEY_SPEED_DBG_EN to add the KEY_DB debounced-pressed debug output.
module key_speed_sel #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] KEY,
  output logic [3:0] SPEED,
  output logic       SPEED_CHG
`ifdef KEY_SPEED_DBG_EN
  ,
  output logic [3:0] KEY_DB
`endif
);
  localparam int W = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_t;
  logic [3:0] meta, sync, db, prev_db, press;
  key_state_t st [4];
  logic [W-1:0] cnt [4];
  // The state's upper bit encodes the debounced level (0 while pressed).
  for (genvar g = 0; g < 4; g++) begin : g_db
    assign db[g] = ~st[g][1];
  end
  assign press = prev_db & ~db;
`ifdef KEY_SPEED_DBG_EN
  assign KEY_DB = ~prev_db;
`endif
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      meta      <= 4'hF;
      sync      <= 4'hF;
      prev_db   <= 4'hF;
      SPEED     <= 4'b0001;
      SPEED_CHG <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        st[k]  <= RELEASED;
        cnt[k] <= '0;
      end
    end else begin
      meta      <= KEY;
      sync      <= meta;
      prev_db   <= db;
      SPEED     <= press[0] ? 4'b0001 : press[1] ? 4'b0010 :
                   press[2] ? 4'b0100 : press[3] ? 4'b1000 : SPEED;
      SPEED_CHG <= |press;
      for (int k = 0; k < 4; k++) begin
        if (sync[k] == db[k]) begin
          cnt[k] <= '0;
          st[k]  <= db[k] ? RELEASED : PRESSED;
        end else if (cnt[k] == W'(DEBOUNCE_CYCLES - 1)) begin
          cnt[k] <= '0;
          st[k]  <= db[k] ? PRESSED : RELEASED;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
          st[k]  <= db[k] ? PRESS_WAIT : RELEASE_WAIT;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_speed_sel.sv
// tb_key_speed_sel: directed and random key stimulus against a history-based model.
module tb_key_speed_sel;
  localparam int N = 4;
  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic [3:0] SPEED;
  logic       SPEED_CHG;
`ifdef KEY_SPEED_DBG_EN
  logic [3:0] KEY_DB;
`endif
  int vectors = 0;
  int miscompares = 0;
  int pulses;
  int pulse_at;
  // Per-edge histories: sampled key, synchronized key, debounced level, prior level.
  logic [3:0] kh[$], sh[$], dbh[$], pdh[$];
  logic [3:0] exp_speed = 4'b0001;
  logic       exp_chg = 1'b0;

  key_speed_sel #(.DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .KEY      (KEY),
    .SPEED    (SPEED),
`ifdef KEY_SPEED_DBG_EN
    .KEY_DB   (KEY_DB),
`endif
    .SPEED_CHG(SPEED_CHG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // A level toggles once the synchronized value has disagreed with it on each of the last N edges.
  task automatic model_edge(input logic rst, input logic [3:0] key);
    int t;
    logic [3:0] ndb, ev;
    bit differs;
    t = kh.size();
    if (rst) begin
      kh.push_back(4'hF); sh.push_back(4'hF); dbh.push_back(4'hF); pdh.push_back(4'hF);
      exp_speed = 4'b0001;
      exp_chg = 1'b0;
    end else begin
      ndb = dbh[t-1];
      for (int b = 0; b < 4; b++) begin
        differs = 1;
        for (int i = 1; i <= N; i++) if (sh[t-i][b] == dbh[t-1][b]) differs = 0;
        if (differs) ndb[b] = ~ndb[b];
      end
      ev = pdh[t-1] & ~dbh[t-1];
      for (int b = 3; b >= 0; b--) if (ev[b]) exp_speed = 4'(1 << b);
      exp_chg = |ev;
      sh.push_back(kh[t-1]);
      kh.push_back(key);
      pdh.push_back(dbh[t-1]);
      dbh.push_back(ndb);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] key, input string tag);
    RESET = rst;
    KEY = key;
    @(posedge CLOCK_50);
    model_edge(rst, key);
    #1;
    check({tag, "_speed"}, SPEED, exp_speed);
    check({tag, "_chg"}, {3'b0, SPEED_CHG}, {3'b0, exp_chg});
`ifdef KEY_SPEED_DBG_EN
    check({tag, "_keydb"}, KEY_DB, ~pdh[pdh.size()-1]);
`endif
    if (SPEED_CHG) pulses++;
  endtask

  task automatic hold(input int n, input logic [3:0] key, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, key, tag);
  endtask

  initial begin
    for (int i = 0; i < N + 3; i++) begin
      kh.push_back(4'hF); sh.push_back(4'hF); dbh.push_back(4'hF); pdh.push_back(4'hF);
    end
    step(1'b1, 4'hF, "reset");
    step(1'b1, 4'hF, "reset");
    check("reset_speed_const", SPEED, 4'b0001);
    hold(12, 4'hF, "idle");
    // Clean press of key 2: pulse expected exactly 6 edges after the first sampling edge.
    pulses = 0;
    pulse_at = -1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 4'hB, "clean");
      if (SPEED_CHG && pulse_at < 0) pulse_at = i;
    end
    check("clean_latency", 4'(pulse_at), 4'd6);
    check("clean_speed_const", SPEED, 4'b0100);
    hold(12, 4'hF, "clean_rel");
    check("clean_pulses", 4'(pulses), 4'd1);
    // Bounce on key 1, then a lone 3-edge glitch.
    pulses = 0;
    hold(3, 4'hD, "bounce");
    hold(1, 4'hF, "bounce");
    hold(12, 4'hD, "bounce");
    check("bounce_speed_const", SPEED, 4'b0010);
    hold(12, 4'hF, "bounce_rel");
    hold(3, 4'hB, "glitch");
    hold(12, 4'hF, "glitch");
    check("bounce_pulses", 4'(pulses), 4'd1);
    // Simultaneous press of keys 0 and 3.
    pulses = 0;
    hold(12, 4'h6, "simul");
    check("simul_speed_const", SPEED, 4'b0001);
    hold(12, 4'h7, "simul_rel0");
    hold(12, 4'h6, "simul_re0");
    check("simul_pulses", 4'(pulses), 4'd2);
    hold(12, 4'hF, "simul_rel");
    // Same key twice.
    pulses = 0;
    hold(12, 4'h7, "twice");
    hold(12, 4'hF, "twice");
    hold(12, 4'h7, "twice");
    check("twice_speed_const", SPEED, 4'b1000);
    check("twice_pulses", 4'(pulses), 4'd2);
    hold(12, 4'hF, "twice_rel");
    // Reset mid-debounce with key 2 held.
    hold(2, 4'hB, "rstmid");
    step(1'b1, 4'hB, "rstmid_rst");
    step(1'b1, 4'hB, "rstmid_rst");
    pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'hB, "rstmid");
      if (SPEED_CHG && pulse_at < 0) pulse_at = i;
    end
    check("rstmid_latency", 4'(pulse_at), 4'd6);
    check("rstmid_speed_const", SPEED, 4'b0100);
    hold(12, 4'hF, "rstmid_rel");
    // Random segments: glitches, holds, multi-key patterns and occasional resets.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 29) == 0) step(1'b1, 4'($urandom), "rnd_rst");
      else hold(int'($urandom_range(1, 9)), 4'($urandom), "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
